// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Purpose : CPU-wide scalar types shared by pipeline blocks.
// Contents: word_t (32-bit machine word / PC).
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage : cpu_types_pkg

// File: rtl/datapath_types_pkg.sv
// datapath_types_pkg
// Purpose : Datapath enums shared between the hazard unit and the branch
//           predictor.
// Contents: pred_t  - branch resolution verdict (2'b11 is unused and is
//                     handled as PRED_NONE by consumers).
//           ctr2_t  - 2-bit saturating direction counter state.
//           ctr_predicts_taken() - direction implied by a counter state.
package datapath_types_pkg;

  typedef enum logic [1:0] {
    PRED_NONE = 2'b00,
    PRED_HIT  = 2'b01,
    PRED_MISS = 2'b10
  } pred_t;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr2_t;

  // The upper half of the counter range means "taken".
  function automatic logic ctr_predicts_taken(input ctr2_t c);
    return (c == CTR_WT) || (c == CTR_ST);
  endfunction

endpackage : datapath_types_pkg

// File: rtl/branch_predictor_if.sv
// branch_predictor_if
// Purpose : Bundles every non-clock, non-reset signal of the branch
//           predictor.
// Signals : fetch_pc       - PC of the instruction in fetch
//           pred_taken     - fetch-stage taken prediction
//           pred_target    - predicted target (fetch_pc+4 when not taken)
//           upd_en         - pipeline advancing; gates training/statistics
//           br_pred_result - resolution verdict from the hazard unit
//           upd_pc         - PC of the resolved branch
//           taken          - actual branch outcome
//           upd_target     - actual branch target
//           br_count       - resolved branches since reset
//           miss_count     - mispredictions since reset
// Modports: bp (predictor side), tb (environment side).
interface branch_predictor_if #(
  parameter int CNT_W = 16
);

  cpu_types_pkg::word_t       fetch_pc;
  logic                       pred_taken;
  cpu_types_pkg::word_t       pred_target;
  logic                       upd_en;
  datapath_types_pkg::pred_t  br_pred_result;
  cpu_types_pkg::word_t       upd_pc;
  logic                       taken;
  cpu_types_pkg::word_t       upd_target;
  logic [CNT_W-1:0]           br_count;
  logic [CNT_W-1:0]           miss_count;

  modport bp (
    input  fetch_pc,
    input  upd_en,
    input  br_pred_result,
    input  upd_pc,
    input  taken,
    input  upd_target,
    output pred_taken,
    output pred_target,
    output br_count,
    output miss_count
  );

  modport tb (
    output fetch_pc,
    output upd_en,
    output br_pred_result,
    output upd_pc,
    output taken,
    output upd_target,
    input  pred_taken,
    input  pred_target,
    input  br_count,
    input  miss_count
  );

endinterface : branch_predictor_if

// File: rtl/sat_counter2.sv
// sat_counter2
// Purpose : Next-state logic of a 2-bit saturating direction counter.
// Ports   : cur_i - present counter state
//           up_i  - 1: step toward strongly-taken, 0: toward strongly-not-taken
//           nxt_o - next counter state (sticks at CTR_ST / CTR_SNT)
module sat_counter2
  import datapath_types_pkg::*;
(
  input  ctr2_t cur_i,
  input  logic  up_i,
  output ctr2_t nxt_o
);

  // Saturating step in the requested direction.
  always_comb begin
    nxt_o = cur_i;
    if (up_i) begin
      case (cur_i)
        CTR_SNT: nxt_o = CTR_WNT;
        CTR_WNT: nxt_o = CTR_WT;
        CTR_WT:  nxt_o = CTR_ST;
        CTR_ST:  nxt_o = CTR_ST;
        default: nxt_o = CTR_WNT;
      endcase
    end else begin
      case (cur_i)
        CTR_SNT: nxt_o = CTR_SNT;
        CTR_WNT: nxt_o = CTR_SNT;
        CTR_WT:  nxt_o = CTR_WNT;
        CTR_ST:  nxt_o = CTR_WT;
        default: nxt_o = CTR_WNT;
      endcase
    end
  end

endmodule : sat_counter2

// File: rtl/branch_predictor.sv
// branch_predictor
// Purpose : Direct-mapped branch target buffer with 2-bit direction
//           counters and resolution statistics.
//           Lookup is combinational on fetch_pc; training happens on the
//           rising edge when the pipeline advances and a branch resolved.
//           A lookup and a training on the same index in the same cycle
//           sees the pre-edge entry.
// Ports   : CLK   - clock, all state updates on rising edge
//           nRST  - asynchronous active-low reset
//           bp_if - branch_predictor_if.bp (fetch lookup, training input,
//                   statistics outputs)
// Params  : ENTRIES - BTB entries, power of two in 2..64
//           CNT_W   - statistics counter width
module branch_predictor
  import cpu_types_pkg::*;
  import datapath_types_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int CNT_W   = 16
) (
  input  logic           CLK,
  input  logic           nRST,
  branch_predictor_if.bp bp_if
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = WORD_W - 2 - IDX_W;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [CNT_W-1:0] stat_t;

  localparam stat_t STAT_MAX = {CNT_W{1'b1}};
  localparam stat_t STAT_ONE = stat_t'(1);

  // BTB storage.
  logic  valid_q  [ENTRIES];
  logic  valid_d  [ENTRIES];
  tag_t  tag_q    [ENTRIES];
  tag_t  tag_d    [ENTRIES];
  word_t target_q [ENTRIES];
  word_t target_d [ENTRIES];
  ctr2_t ctr_q    [ENTRIES];
  ctr2_t ctr_d    [ENTRIES];

  stat_t br_count_q;
  stat_t br_count_d;
  stat_t miss_count_q;
  stat_t miss_count_d;

  // Lookup side.
  idx_t  f_idx_s;
  tag_t  f_tag_s;
  logic  f_hit_s;
  logic  pred_taken_s;
  word_t pred_target_s;

  // Training side.
  idx_t  u_idx_s;
  tag_t  u_tag_s;
  logic  u_hit_s;
  logic  resolved_s;
  logic  train_s;
  logic  train_miss_s;
  ctr2_t ctr_nxt_s;

  // The byte offset of upd_pc never selects anything.
  logic  unused_upd_pc_lsb_s;
  assign unused_upd_pc_lsb_s = ^bp_if.upd_pc[1:0];

  // Fetch-stage lookup; pred_target falls through to the next word unless
  // the entry both matches and points taken.
  always_comb begin
    f_idx_s = bp_if.fetch_pc[IDX_W+1:2];
    f_tag_s = bp_if.fetch_pc[WORD_W-1:IDX_W+2];
    f_hit_s = valid_q[f_idx_s] && (tag_q[f_idx_s] == f_tag_s);
    pred_taken_s = f_hit_s && ctr_predicts_taken(ctr_q[f_idx_s]);
    if (pred_taken_s) begin
      pred_target_s = target_q[f_idx_s];
    end else begin
      pred_target_s = bp_if.fetch_pc + 32'd4;
    end
  end

  // Decode the resolution verdict; the unused 2'b11 code counts as no branch.
  always_comb begin
    resolved_s = 1'b0;
    case (bp_if.br_pred_result)
      PRED_HIT:  resolved_s = 1'b1;
      PRED_MISS: resolved_s = 1'b1;
      default:   resolved_s = 1'b0;
    endcase
    train_s      = bp_if.upd_en && resolved_s;
    train_miss_s = bp_if.upd_en && (bp_if.br_pred_result == PRED_MISS);
    u_idx_s      = bp_if.upd_pc[IDX_W+1:2];
    u_tag_s      = bp_if.upd_pc[WORD_W-1:IDX_W+2];
    u_hit_s      = valid_q[u_idx_s] && (tag_q[u_idx_s] == u_tag_s);
  end

  sat_counter2 u_sat_counter2 (
    .cur_i (ctr_q[u_idx_s]),
    .up_i  (bp_if.taken),
    .nxt_o (ctr_nxt_s)
  );

  // Next BTB contents: train on a tag hit, allocate on a taken miss,
  // otherwise leave the entry alone.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (train_s) begin
      if (u_hit_s) begin
        ctr_d[u_idx_s] = ctr_nxt_s;
        if (bp_if.taken) begin
          target_d[u_idx_s] = bp_if.upd_target;
        end else begin
          target_d[u_idx_s] = target_q[u_idx_s];
        end
      end else if (bp_if.taken) begin
        valid_d[u_idx_s]  = 1'b1;
        tag_d[u_idx_s]    = u_tag_s;
        target_d[u_idx_s] = bp_if.upd_target;
        ctr_d[u_idx_s]    = CTR_WT;
      end else begin
        valid_d[u_idx_s] = valid_q[u_idx_s];
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Next statistics; both counters stick at all-ones.
  always_comb begin
    br_count_d   = br_count_q;
    miss_count_d = miss_count_q;
    if (train_s && (br_count_q != STAT_MAX)) begin
      br_count_d = br_count_q + STAT_ONE;
    end else begin
      br_count_d = br_count_q;
    end
    if (train_miss_s && (miss_count_q != STAT_MAX)) begin
      miss_count_d = miss_count_q + STAT_ONE;
    end else begin
      miss_count_d = miss_count_q;
    end
  end

  // State registers; reset invalidates every entry and parks counters at WNT.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= {TAG_W{1'b0}};
        target_q[i] <= 32'h0000_0000;
        ctr_q[i]    <= CTR_WNT;
      end
      br_count_q   <= {CNT_W{1'b0}};
      miss_count_q <= {CNT_W{1'b0}};
    end else begin
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      target_q     <= target_d;
      ctr_q        <= ctr_d;
      br_count_q   <= br_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign bp_if.pred_taken  = pred_taken_s;
  assign bp_if.pred_target = pred_target_s;
  assign bp_if.br_count    = br_count_q;
  assign bp_if.miss_count  = miss_count_q;

endmodule : branch_predictor

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
// Directed bench for branch_predictor (ENTRIES=8, CNT_W=4). A reference
// model of the BTB keyed by word address is checked against the DUT every
// cycle, and literal expectations pin both the DUT and the model at the
// interesting points of the sequence.
module tb_branch_predictor;
  import cpu_types_pkg::*;
  import datapath_types_pkg::*;

  localparam int ENTRIES  = 8;
  localparam int CNT_W    = 4;
  localparam int STAT_MAX = (1 << CNT_W) - 1;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  branch_predictor_if #(.CNT_W(CNT_W)) bp_if ();

  branch_predictor #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .bp_if (bp_if)
  );

  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: one slot per index, remembering the full word address
  // of the branch it holds, its target and a 0..3 confidence value.
  bit    m_valid [ENTRIES];
  word_t m_word  [ENTRIES];
  word_t m_tgt   [ENTRIES];
  int    m_ctr   [ENTRIES];
  int    m_br;
  int    m_miss;

  function automatic int m_idx(input word_t pc);
    return int'((pc / 32'd4) % ENTRIES);
  endfunction

  function automatic bit m_hit(input word_t pc);
    return m_valid[m_idx(pc)] && (m_word[m_idx(pc)] == pc / 32'd4);
  endfunction

  function automatic bit m_taken(input word_t pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic word_t m_target(input word_t pc);
    return m_taken(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] <= 1'b0;
        m_word[k]  <= 32'd0;
        m_tgt[k]   <= 32'd0;
        m_ctr[k]   <= 1;
      end
      m_br   <= 0;
      m_miss <= 0;
    end else if (bp_if.upd_en &&
                 (bp_if.br_pred_result == PRED_HIT || bp_if.br_pred_result == PRED_MISS)) begin
      m_br <= (m_br < STAT_MAX) ? m_br + 1 : STAT_MAX;
      if (bp_if.br_pred_result == PRED_MISS)
        m_miss <= (m_miss < STAT_MAX) ? m_miss + 1 : STAT_MAX;
      if (m_hit(bp_if.upd_pc)) begin
        if (bp_if.taken) begin
          m_ctr[m_idx(bp_if.upd_pc)] <= (m_ctr[m_idx(bp_if.upd_pc)] < 3) ? m_ctr[m_idx(bp_if.upd_pc)] + 1 : 3;
          m_tgt[m_idx(bp_if.upd_pc)] <= bp_if.upd_target;
        end else begin
          m_ctr[m_idx(bp_if.upd_pc)] <= (m_ctr[m_idx(bp_if.upd_pc)] > 0) ? m_ctr[m_idx(bp_if.upd_pc)] - 1 : 0;
        end
      end else if (bp_if.taken) begin
        m_valid[m_idx(bp_if.upd_pc)] <= 1'b1;
        m_word[m_idx(bp_if.upd_pc)]  <= bp_if.upd_pc / 32'd4;
        m_tgt[m_idx(bp_if.upd_pc)]   <= bp_if.upd_target;
        m_ctr[m_idx(bp_if.upd_pc)]   <= 2;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic cmp_model();
    chk("cyc_pred_taken",  32'(bp_if.pred_taken),  32'(m_taken(bp_if.fetch_pc)));
    chk("cyc_pred_target", bp_if.pred_target,      m_target(bp_if.fetch_pc));
    chk("cyc_br_count",    32'(bp_if.br_count),    32'(m_br));
    chk("cyc_miss_count",  32'(bp_if.miss_count),  32'(m_miss));
  endtask

  // Literal expectation, applied to both the DUT and the model.
  task automatic lit(input string name, input logic et, input word_t etg, input int ebr, input int emiss);
    chk({name, "_taken"},      32'(bp_if.pred_taken),          32'(et));
    chk({name, "_target"},     bp_if.pred_target,              etg);
    chk({name, "_br"},         32'(bp_if.br_count),            32'(ebr));
    chk({name, "_miss"},       32'(bp_if.miss_count),          32'(emiss));
    chk({name, "_mdl_taken"},  32'(m_taken(bp_if.fetch_pc)),   32'(et));
    chk({name, "_mdl_target"}, m_target(bp_if.fetch_pc),       etg);
    chk({name, "_mdl_br"},     32'(m_br),                      32'(ebr));
    chk({name, "_mdl_miss"},   32'(m_miss),                    32'(emiss));
  endtask

  // One cycle: compare at the falling edge, then drive the next inputs.
  task automatic apply(input logic rstv, input word_t fpc, input logic en, input logic [1:0] res,
                       input word_t upc, input logic tk, input word_t tgt);
    @(negedge CLK);
    cmp_model();
    #1;
    nRST                 = rstv;
    bp_if.fetch_pc       = fpc;
    bp_if.upd_en         = en;
    bp_if.br_pred_result = pred_t'(res);
    bp_if.upd_pc         = upc;
    bp_if.taken          = tk;
    bp_if.upd_target     = tgt;
    #1;
  endtask

  task automatic look(input logic rstv, input word_t fpc);
    apply(rstv, fpc, 1'b0, 2'b00, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    bp_if.fetch_pc       = 32'd0;
    bp_if.upd_en         = 1'b0;
    bp_if.br_pred_result = PRED_NONE;
    bp_if.upd_pc         = 32'd0;
    bp_if.taken          = 1'b0;
    bp_if.upd_target     = 32'd0;

    // Reset state.
    look(1'b0, 32'h40);                                      lit("rst",        1'b0, 32'h44,  0, 0);
    // Allocate 0x40 -> 0x100 on a miss; same-cycle lookup still sees empty.
    apply(1'b1, 32'h40, 1'b1, 2'b10, 32'h40, 1'b1, 32'h100); lit("alloc_pre",  1'b0, 32'h44,  0, 0);
    look(1'b1, 32'h40);                                      lit("alloc",      1'b1, 32'h100, 1, 1);
    // WT -> WNT (lookup this cycle still old) -> SNT -> SNT -> WNT.
    apply(1'b1, 32'h40, 1'b1, 2'b01, 32'h40, 1'b0, 32'h200); lit("nt1_pre",    1'b1, 32'h100, 1, 1);
    apply(1'b1, 32'h40, 1'b1, 2'b01, 32'h40, 1'b0, 32'h0);   lit("wnt",        1'b0, 32'h44,  2, 1);
    apply(1'b1, 32'h40, 1'b1, 2'b10, 32'h40, 1'b0, 32'h0);   lit("snt",        1'b0, 32'h44,  3, 1);
    apply(1'b1, 32'h40, 1'b1, 2'b01, 32'h40, 1'b1, 32'h180); lit("snt_hold",   1'b0, 32'h44,  4, 2);
    apply(1'b1, 32'h40, 1'b1, 2'b01, 32'h40, 1'b1, 32'h180); lit("wnt_again",  1'b0, 32'h44,  5, 2);
    look(1'b1, 32'h40);                                      lit("wt_newtgt",  1'b1, 32'h180, 6, 2);
    // Aliasing: 0x60 shares index 0 with 0x40 and replaces it.
    apply(1'b1, 32'h60, 1'b1, 2'b10, 32'h60, 1'b1, 32'h300); lit("alias_pre",  1'b0, 32'h64,  6, 2);
    look(1'b1, 32'h40);                                      lit("alias_old",  1'b0, 32'h44,  7, 3);
    look(1'b1, 32'h60);                                      lit("alias_new",  1'b1, 32'h300, 7, 3);
    // upd_en=0 blocks allocation, training and statistics.
    apply(1'b1, 32'h48, 1'b0, 2'b10, 32'h48, 1'b1, 32'h400); lit("noen_a",     1'b0, 32'h4C,  7, 3);
    apply(1'b1, 32'h48, 1'b0, 2'b01, 32'h60, 1'b0, 32'h0);   lit("noen_b",     1'b0, 32'h4C,  7, 3);
    // Same-cycle lookup/train on 0x60 returns the old (taken) value.
    apply(1'b1, 32'h60, 1'b1, 2'b01, 32'h60, 1'b0, 32'h0);   lit("same_cyc",   1'b1, 32'h300, 7, 3);
    // Code 2'b11 behaves as no branch.
    apply(1'b1, 32'h60, 1'b1, 2'b11, 32'h60, 1'b1, 32'h500); lit("res11_pre",  1'b0, 32'h64,  8, 3);
    look(1'b1, 32'h60);                                      lit("res11",      1'b0, 32'h64,  8, 3);
    // Byte offset is ignored: train with 0x5F, hit with 0x5C and 0x5E.
    apply(1'b1, 32'h5C, 1'b1, 2'b10, 32'h5F, 1'b1, 32'h600); lit("lsb_pre",    1'b0, 32'h60,  8, 3);
    look(1'b1, 32'h5C);                                      lit("lsb_5c",     1'b1, 32'h600, 9, 4);
    look(1'b1, 32'h5E);                                      lit("lsb_5e",     1'b1, 32'h600, 9, 4);
    // Statistics saturate at 4'hF.
    for (int i = 0; i < 20; i++) apply(1'b1, 32'h70, 1'b1, 2'b10, 32'h70, 1'b1, 32'h700);
    look(1'b1, 32'h70);                                      lit("sat",        1'b1, 32'h700, STAT_MAX, STAT_MAX);
    // Reset pulse clears statistics and invalidates every entry.
    look(1'b0, 32'h70);                                      lit("rst2",       1'b0, 32'h74,  0, 0);
    look(1'b1, 32'h70);                                      lit("inv_70",     1'b0, 32'h74,  0, 0);
    look(1'b1, 32'h60);                                      lit("inv_60",     1'b0, 32'h64,  0, 0);
    look(1'b1, 32'h5C);                                      lit("inv_5c",     1'b0, 32'h60,  0, 0);
    // Training while in reset is discarded; the first edge after release trains.
    apply(1'b0, 32'h40, 1'b1, 2'b10, 32'h40, 1'b1, 32'h800); lit("rst_train",  1'b0, 32'h44,  0, 0);
    apply(1'b1, 32'h40, 1'b1, 2'b10, 32'h40, 1'b1, 32'h800); lit("post_pre",   1'b0, 32'h44,  0, 0);
    look(1'b1, 32'h40);                                      lit("post_rst",   1'b1, 32'h800, 1, 1);

    @(negedge CLK);
    cmp_model();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_branch_predictor
